// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
//   stall_cause_e : encoding of the stall_cause output
//   force_state_e : states of the forced one-shot stall FSM
//   CAUSE_W       : width of the stall_cause output
//   BUSY_W        : width of the multi-cycle unit busy counter
//   FCNT_W        : width of the forced-stall cycle counter
package hazard_pkg;

   localparam int CAUSE_W = 2;
   localparam int BUSY_W  = 4;
   localparam int FCNT_W  = 3;

   typedef enum logic [CAUSE_W-1:0] {
      NONE           = 2'd0,
      LOAD_USE       = 2'd1,
      BRANCH         = 2'd2,
      MULTI_OR_FORCE = 2'd3
   } stall_cause_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } force_state_e;

endpackage

// File: rtl/hazard_force_oneshot.sv
// Forced one-shot stall generator. Every rising edge of force_req seen in
// IDLE produces exactly FORCE_LEN cycles of force_active, starting in the
// edge cycle itself. After the burst the FSM waits in DONE until force_req
// is observed low, so a held request never retriggers.
// Ports:
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   force_req    in  level request for a forced stall
//   force_active out forced stall active this cycle
module hazard_force_oneshot
   import hazard_pkg::*;
#(
   parameter int FORCE_LEN = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic force_req,
   output logic force_active
);

   localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FORCE_LEN - 1);

   force_state_e      state_q, state_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              force_req_q;
   logic              force_rise;

   assign force_rise = force_req & ~force_req_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fcnt_q      <= '0;
         force_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fcnt_q      <= fcnt_d;
         force_req_q <= force_req;
      end
   end

   // fcnt holds the stall cycles still owed after the current one, so the
   // edge cycle plus the RUN cycles add up to exactly FORCE_LEN.
   always_comb begin
      state_d      = state_q;
      fcnt_d       = fcnt_q;
      force_active = 1'b0;
      case (state_q)
         IDLE: begin
            if (force_rise) begin
               force_active = 1'b1;
               fcnt_d       = FCNT_LOAD;
               state_d      = (FORCE_LEN == 1) ? DONE : RUN;
            end
         end
         RUN: begin
            force_active = 1'b1;
            if (fcnt_q == FCNT_W'(1)) begin
               fcnt_d  = '0;
               state_d = DONE;
            end else begin
               fcnt_d = fcnt_q - FCNT_W'(1);
            end
         end
         DONE: begin
            if (!force_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller sitting beside ID. Detects load-use,
// branch/jr operand, multi-cycle-unit busy and forced-stall conditions and
// drives a single combinational stall to hold IF/ID and bubble ID/EX.
// Optional feature: define HAZARD_PERF_EN to enable the 32-bit stall-cycle
// counter on stall_cnt; otherwise stall_cnt is tied to zero.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_src_rd       per-operand register-read flags
//   id_src_addr     operand addresses, operand i at [i*AW +: AW]
//   id_is_branch    ID instr resolves branch/jr in ID
//   id_uses_multi   ID instr reads the multi-cycle unit result
//   ex_wen/ex_is_load/ex_addr   EX stage destination info
//   me_is_load/me_addr          MEM stage load destination info
//   multi_start     multi-cycle op issued (ignored while stalling)
//   force_req       level request for a forced stall
//   ifid_wait_stop  hold PC and IF/ID
//   idexe_reset     insert bubble into ID/EX
//   stall_cause     highest-priority stall reason
//   stall_cnt       stall-cycle counter
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int AW        = 5,
   parameter int NUM_SRC   = 2,
   parameter int MULTI_LAT = 4,
   parameter int FORCE_LEN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SRC-1:0]    id_src_rd,
   input  logic [NUM_SRC*AW-1:0] id_src_addr,
   input  logic                  id_is_branch,
   input  logic                  id_uses_multi,
   input  logic                  ex_wen,
   input  logic                  ex_is_load,
   input  logic [AW-1:0]         ex_addr,
   input  logic                  me_is_load,
   input  logic [AW-1:0]         me_addr,
   input  logic                  multi_start,
   input  logic                  force_req,
   output logic                  ifid_wait_stop,
   output logic                  idexe_reset,
   output logic [CAUSE_W-1:0]    stall_cause,
   output logic [31:0]           stall_cnt
);

   logic [NUM_SRC-1:0] lu_vec;
   logic [NUM_SRC-1:0] br_vec;
   logic               load_use;
   logic               branch_haz;
   logic               multi_haz;
   logic               force_active;
   logic               stall;
   logic [BUSY_W-1:0]  busy_q, busy_d;
   stall_cause_e       cause;

   // Register 0 is hard-wired zero, so a read of it never depends on anything.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [AW-1:0] addr;
      logic          rd_nz;
      assign addr      = id_src_addr[i*AW +: AW];
      assign rd_nz     = id_src_rd[i] & (addr != '0);
      assign lu_vec[i] = rd_nz & ex_is_load & (addr == ex_addr);
      assign br_vec[i] = rd_nz & ((ex_wen & (addr == ex_addr)) |
                                  (me_is_load & (addr == me_addr)));
   end

   assign load_use   = |lu_vec;
   assign branch_haz = id_is_branch & (|br_vec);
   assign multi_haz  = id_uses_multi & (busy_q != '0);

   hazard_force_oneshot #(
      .FORCE_LEN (FORCE_LEN)
   ) u_force (
      .clk          (clk),
      .rst          (rst),
      .force_req    (force_req),
      .force_active (force_active)
   );

   // Outputs are held low while reset is asserted.
   assign stall = ~rst & (load_use | branch_haz | multi_haz | force_active);
   assign ifid_wait_stop = stall;
   assign idexe_reset    = stall;

   always_comb begin
      cause = NONE;
      if (!rst) begin
         if (load_use)                       cause = LOAD_USE;
         else if (branch_haz)                cause = BRANCH;
         else if (multi_haz || force_active) cause = MULTI_OR_FORCE;
      end
   end
   assign stall_cause = cause;

   // A start issued during a stall is not really issued, so it is ignored;
   // the countdown itself keeps running through stalls.
   always_comb begin
      busy_d = busy_q;
      if (multi_start && !stall) busy_d = BUSY_W'(MULTI_LAT);
      else if (busy_q != '0)     busy_d = busy_q - BUSY_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   always_ff @(posedge clk) begin
      if (rst)        stall_cnt_q <= '0;
      else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
   end
   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic, each
// cycle's expected outputs produced by a behavioural model and queued for a
// separate negedge monitor.
module tb_hazard_ctrl;

   localparam int AW        = 5;
   localparam int NUM_SRC   = 2;
   localparam int MULTI_LAT = 4;
   localparam int FORCE_LEN = 3;
   localparam int W         = 36;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_SRC-1:0]    id_src_rd;
   logic [NUM_SRC*AW-1:0] id_src_addr;
   logic                  id_is_branch, id_uses_multi;
   logic                  ex_wen, ex_is_load;
   logic [AW-1:0]         ex_addr;
   logic                  me_is_load;
   logic [AW-1:0]         me_addr;
   logic                  multi_start, force_req;
   logic                  ifid_wait_stop, idexe_reset;
   logic [1:0]            stall_cause;
   logic [31:0]           stall_cnt;

   hazard_ctrl #(
      .AW(AW), .NUM_SRC(NUM_SRC), .MULTI_LAT(MULTI_LAT), .FORCE_LEN(FORCE_LEN)
   ) dut (
      .clk(clk), .rst(rst),
      .id_src_rd(id_src_rd), .id_src_addr(id_src_addr),
      .id_is_branch(id_is_branch), .id_uses_multi(id_uses_multi),
      .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_addr(ex_addr),
      .me_is_load(me_is_load), .me_addr(me_addr),
      .multi_start(multi_start), .force_req(force_req),
      .ifid_wait_stop(ifid_wait_stop), .idexe_reset(idexe_reset),
      .stall_cause(stall_cause), .stall_cnt(stall_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc    = 0;

   // ---------------- reference model state ----------------
   int          m_busy;       // cycles the multi-cycle unit remains busy
   int          m_fleft;      // forced stall cycles still owed after this one
   int          m_burst_end;  // first cycle after the last forced burst
   bit          m_prev_req;
   int unsigned m_cnt;

   task automatic model_reset();
      m_busy      = 0;
      m_fleft     = 0;
      m_burst_end = -100;
      m_prev_req  = 1'b0;
      m_cnt       = 0;
   endtask

   // Evaluate the current inputs, queue expected outputs, advance one clock.
   task automatic cycle();
      bit lu, br, mh, fa, st, rising, started;
      logic [1:0]   cause;
      logic [31:0]  cnt_exp;
      logic [AW-1:0] a;
      lu = 0; br = 0; started = 0;
      if (rst) begin
         exp_q.push_back('0);
         @(posedge clk);
         model_reset();
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            a = id_src_addr[i*AW +: AW];
            if (id_src_rd[i] && a != 0) begin
               if (ex_is_load && a == ex_addr) lu = 1;
               if (id_is_branch && ((ex_wen && a == ex_addr) || (me_is_load && a == me_addr))) br = 1;
            end
         end
         mh = id_uses_multi && (m_busy != 0);
         rising = force_req && !m_prev_req;
         if (m_fleft > 0) fa = 1;
         else if (rising && cyc > m_burst_end) begin
            fa = 1;
            started = 1;
         end else fa = 0;
         st = lu | br | mh | fa;
         cause = lu ? 2'd1 : br ? 2'd2 : (mh | fa) ? 2'd3 : 2'd0;
         if (st) m_cnt = m_cnt + 1;
`ifdef HAZARD_PERF_EN
         cnt_exp = m_cnt;
`else
         cnt_exp = 32'd0;
`endif
         exp_q.push_back({st, st, cause, cnt_exp});
         @(posedge clk);
         if (m_fleft > 0) m_fleft = m_fleft - 1;
         else if (started) begin
            m_fleft     = FORCE_LEN - 1;
            m_burst_end = cyc + FORCE_LEN;
         end
         if (multi_start && !st) m_busy = MULTI_LAT;
         else if (m_busy > 0)    m_busy = m_busy - 1;
         m_prev_req = force_req;
      end
      cyc = cyc + 1;
      #1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e, act;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         act = {ifid_wait_stop, idexe_reset, stall_cause, stall_cnt};
         checks = checks + 1;
         if (act !== e)
            $display("FAIL outputs cyc=%0d got stop=%b bub=%b cause=%0d cnt=%0d expected stop=%b bub=%b cause=%0d cnt=%0d",
                     cyc, act[35], act[34], act[33:32], act[31:0], e[35], e[34], e[33:32], e[31:0]);
         if (act !== e) errors = errors + 1;
      end
   end

   // ---------------- driver ----------------
   task automatic idle_inputs();
      id_src_rd = '0; id_src_addr = '0; id_is_branch = 0; id_uses_multi = 0;
      ex_wen = 0; ex_is_load = 0; ex_addr = '0; me_is_load = 0; me_addr = '0;
      multi_start = 0;
   endtask

   initial begin
      rst = 1; force_req = 0;
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      cycle(); cycle();
      rst = 0;
      cycle();

      // load-use on operand 0, then register 0 never hazards
      ex_is_load = 1; ex_addr = 5'd8; id_src_rd = 2'b01; id_src_addr = {5'd0, 5'd8};
      cycle();
      ex_addr = 5'd0; id_src_addr = {5'd0, 5'd0};
      cycle();
      idle_inputs(); cycle();

      // branch operand 1 against EX writer, then MEM load, then clear
      id_is_branch = 1; id_src_rd = 2'b10; id_src_addr = {5'd9, 5'd0};
      ex_wen = 1; ex_addr = 5'd9;
      cycle();
      ex_wen = 0; me_is_load = 1; me_addr = 5'd9;
      cycle();
      me_is_load = 0;
      cycle();
      idle_inputs(); cycle();

      // multi-cycle busy window
      multi_start = 1; cycle();
      multi_start = 0; id_uses_multi = 1;
      repeat (7) cycle();
      idle_inputs(); cycle();

      // forced stall held 10 cycles, then drop and raise again
      force_req = 1; repeat (10) cycle();
      force_req = 0; cycle();
      force_req = 1; repeat (5) cycle();
      force_req = 0; repeat (2) cycle();

      // reset in the middle of a forced stall with the unit busy
      multi_start = 1; cycle();
      multi_start = 0; id_uses_multi = 1; force_req = 1;
      cycle(); cycle();
      rst = 1; force_req = 0; cycle();
      rst = 0; repeat (4) cycle();
      idle_inputs(); cycle();

      // randomized traffic on a narrow address range
      for (int n = 0; n < 600; n++) begin
         rst           = ($urandom_range(0, 79) == 0);
         id_src_rd     = NUM_SRC'($urandom_range(0, 3));
         id_src_addr   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_is_branch  = ($urandom_range(0, 3) == 0);
         id_uses_multi = ($urandom_range(0, 2) == 0);
         ex_wen        = $urandom_range(0, 1);
         ex_is_load    = ($urandom_range(0, 3) == 0);
         ex_addr       = 5'($urandom_range(0, 3));
         me_is_load    = ($urandom_range(0, 3) == 0);
         me_addr       = 5'($urandom_range(0, 3));
         multi_start   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 5) == 0) force_req = ~force_req;
         cycle();
      end
      rst = 0; idle_inputs(); force_req = 0;
      cycle();

      @(negedge clk); #1;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
         errors = errors + 1;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
